// File: rtl/uart_rx.sv
// 8N1-style serial receiver: 2-flop input synchronizer, mid-bit sampling FSM,
// one-entry holding register with valid/ready handshake and sticky overrun.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1406,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0
) (
    input  logic                 clock,
    input  logic                 reset_b,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 clear_overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e                 state_q, state_d;
    logic                   sync1_q, rxs_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   perr_hold_q, perr_hold_d;
    logic                   ovr_q, ovr_d;
    logic                   ovr_set;
    logic                   par_x;

    // Synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rxd;
            rxs_q   <= sync1_q;
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            perr_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            perr_hold_q <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            perr_q      <= perr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            perr_hold_q <= perr_hold_d;
            ovr_q       <= ovr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        perr_d      = perr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        ferr_d      = ferr_q;
        perr_hold_d = perr_hold_q;
        ovr_set     = 1'b0;
        par_x       = (^shift_q) ^ rxs_q;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                perr_d = 1'b0;
                if (!rxs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A start bit that is gone by mid-bit was a glitch.
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_IDX) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    perr_d  = (PARITY == 2) ? ~par_x : par_x;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    // A simultaneous transfer frees the slot for this byte.
                    if (!valid_q || ready) begin
                        data_d      = shift_q;
                        ferr_d      = ~rxs_q;
                        perr_hold_d = perr_q;
                        valid_d     = 1'b1;
                    end else begin
                        ovr_set = 1'b1;
                    end
                    state_d = rxs_q ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (clear_overrun) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_hold_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks/bit: one no-parity instance plus
// even- and odd-parity instances sharing a second serial line.
module tb_uart_rx;

    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_b, line, sel;
    logic rxd0, rxdp;
    assign rxd0 = sel ? 1'b1 : line;
    assign rxdp = sel ? line : 1'b1;

    logic [7:0] data0, data1, data2;
    logic valid0, valid1, valid2, fe0, fe1, fe2, pe0, pe1, pe2;
    logic ovr0, ovr1, ovr2, busy0, busy1, busy2;
    logic ready0, clr0, ready_p;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0)) u0 (
        .clock(clk), .reset_b(reset_b), .rxd(rxd0), .data(data0), .valid(valid0),
        .ready(ready0), .frame_err(fe0), .parity_err(pe0), .overrun(ovr0),
        .clear_overrun(clr0), .busy(busy0));

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1)) u1 (
        .clock(clk), .reset_b(reset_b), .rxd(rxdp), .data(data1), .valid(valid1),
        .ready(ready_p), .frame_err(fe1), .parity_err(pe1), .overrun(ovr1),
        .clear_overrun(1'b0), .busy(busy1));

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2)) u2 (
        .clock(clk), .reset_b(reset_b), .rxd(rxdp), .data(data2), .valid(valid2),
        .ready(ready_p), .frame_err(fe2), .parity_err(pe2), .overrun(ovr2),
        .clear_overrun(1'b0), .busy(busy2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   rises0 = 0, high0 = 0, rise_cyc = 0;
    logic vprev = 1'b0;
    always @(negedge clk) begin
        vprev <= valid0;
        if (valid0 && !vprev) begin
            rises0   <= rises0 + 1;
            rise_cyc <= cyc;
        end
        if (valid0) high0 <= high0 + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        line = b;
        repeat (CPB) @(negedge clk);
    endtask

    // par < 0 means no parity bit; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input int par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        if (par >= 0) send_bit(par[0]);
        send_bit(stop);
    endtask

    int t0, b_rise, b_high, lat;

    initial begin
        reset_b = 1'b0; line = 1'b1; sel = 1'b0;
        ready0 = 1'b1; clr0 = 1'b0; ready_p = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data0), 32'h0);
        check("rst_valid", 32'(valid0), 32'h0);
        check("rst_busy", 32'(busy0), 32'h0);
        check("rst_ovr", 32'(ovr0), 32'h0);
        reset_b = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte, consumer always ready
        t0 = cyc; b_rise = rises0; b_high = high0;
        send_frame(8'hA5, -1, 1'b1);
        repeat (10) @(negedge clk);
        lat = rise_cyc - t0;
        check("t1_rises", 32'(rises0 - b_rise), 32'd1);
        check("t1_high_cycles", 32'(high0 - b_high), 32'd1);
        check("t1_latency_in_154_156", 32'((lat >= 154) && (lat <= 156)), 32'd1);
        check("t1_data", 32'(data0), 32'hA5);
        check("t1_frame_err", 32'(fe0), 32'h0);

        // Overrun with consumer stalled
        ready0 = 1'b0;
        send_frame(8'h3C, -1, 1'b1);
        send_frame(8'h7E, -1, 1'b1);
        repeat (10) @(negedge clk);
        check("t2_data_kept", 32'(data0), 32'h3C);
        check("t2_valid", 32'(valid0), 32'h1);
        check("t2_overrun", 32'(ovr0), 32'h1);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        check("t2_overrun_cleared", 32'(ovr0), 32'h0);
        check("t2_valid_after_clear", 32'(valid0), 32'h1);
        ready0 = 1'b1;
        @(negedge clk);
        check("t2_valid_consumed", 32'(valid0), 32'h0);
        check("t2_data_holds", 32'(data0), 32'h3C);

        // Framing error followed by a stuck-low line
        b_rise = rises0;
        send_frame(8'h55, -1, 1'b0);
        repeat (40 * CPB) @(negedge clk);
        check("t3_one_delivery", 32'(rises0 - b_rise), 32'd1);
        check("t3_data", 32'(data0), 32'h55);
        check("t3_frame_err", 32'(fe0), 32'h1);
        check("t3_busy_low_line", 32'(busy0), 32'h1);
        line = 1'b1;
        repeat (5) @(negedge clk);
        check("t3_busy_released", 32'(busy0), 32'h0);
        check("t3_no_repeat", 32'(rises0 - b_rise), 32'd1);

        // Short glitch on an idle line
        b_rise = rises0;
        line = 1'b0;
        repeat (6) @(negedge clk);
        line = 1'b1;
        repeat (40) @(negedge clk);
        check("t4_no_valid", 32'(rises0 - b_rise), 32'd0);
        check("t4_idle", 32'(busy0), 32'h0);
        check("t4_no_overrun", 32'(ovr0), 32'h0);

        // Parity: 0x07 has odd weight
        sel = 1'b1;
        send_frame(8'h07, 1, 1'b1);
        repeat (10) @(negedge clk);
        check("t5a_data_even", 32'(data1), 32'h07);
        check("t5a_pe_even", 32'(pe1), 32'h0);
        check("t5a_pe_odd", 32'(pe2), 32'h1);
        check("t5a_fe_even", 32'(fe1), 32'h0);
        send_frame(8'h07, 0, 1'b1);
        repeat (10) @(negedge clk);
        check("t5b_data_odd", 32'(data2), 32'h07);
        check("t5b_pe_even", 32'(pe1), 32'h1);
        check("t5b_pe_odd", 32'(pe2), 32'h0);
        sel = 1'b0;
        repeat (5) @(negedge clk);

        // Reset during data bit 4
        ready0 = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        line = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        check("t6_busy_mid_frame", 32'(busy0), 32'h1);
        reset_b = 1'b0;
        line = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", 32'(valid0), 32'h0);
        check("t6_rst_busy", 32'(busy0), 32'h0);
        check("t6_rst_data", 32'(data0), 32'h0);
        check("t6_rst_fe", 32'(fe0), 32'h0);
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_no_partial_byte", 32'(valid0), 32'h0);
        send_frame(8'hC3, -1, 1'b1);
        repeat (10) @(negedge clk);
        check("t6_data", 32'(data0), 32'hC3);
        check("t6_valid", 32'(valid0), 32'h1);
        check("t6_fe", 32'(fe0), 32'h0);
        check("t6_pe", 32'(pe0), 32'h0);
        check("t6_ovr", 32'(ovr0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
